// File: rtl/slotmaker_pkg.sv
// Shared constants, card IDs and sequencer state encoding for the slot sequencer.
// The reset map contents are selected in slotmaker_sequencer via SLOTMAKER_DEFAULT_MAP_EN.
package slotmaker_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int CARD_W    = 8;

  localparam logic [CARD_W-1:0] CARD_NONE         = 8'h00;
  localparam logic [CARD_W-1:0] CARD_MOCKINGBOARD = 8'h01;
  localparam logic [CARD_W-1:0] CARD_SUPERSPRITE  = 8'h02;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/slotmaker_sequencer.sv
// Slot map sequencer: CPU-written shadow map, detach/attach sweep over all slots, atomic commit.
// Define SLOTMAKER_DEFAULT_MAP_EN to reset with a Mockingboard in slot 4 and a SuperSprite in slot 7.
module slotmaker_sequencer
  import slotmaker_pkg::*;
#(
  parameter int NUM_SLOTS = slotmaker_pkg::NUM_SLOTS,
  parameter int CARD_W    = slotmaker_pkg::CARD_W
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [2:0]                  cfg_slot,
  input  logic [CARD_W-1:0]           cfg_card_i,
  input  logic                        cfg_wr,
  input  logic                        cfg_reconfig,
  output logic [CARD_W-1:0]           cfg_card_o,
  output logic                        seq_busy,
  output logic [2:0]                  seq_slot,
  output logic [CARD_W-1:0]           seq_card,
  output logic                        seq_clear,
  output logic                        seq_strobe,
  output logic [NUM_SLOTS*CARD_W-1:0] active_map,
  output logic                        commit_pulse
);

  state_e                        state_q;
  logic [3:0]                    ph_q;
  logic [2:0]                    seq_slot_q;
  logic [CARD_W-1:0]             seq_card_q;
  logic                          seq_clear_q;
  logic                          seq_strobe_q;
  logic                          seq_busy_q;
  logic                          commit_pulse_q;
  logic [NUM_SLOTS*CARD_W-1:0]   active_map_q;
  logic [CARD_W-1:0]             cfg_card_o_q;
  logic [CARD_W-1:0]             shadow_q   [NUM_SLOTS];
  logic [CARD_W-1:0]             snapshot_q [NUM_SLOTS];

  logic [CARD_W-1:0]             reset_card [NUM_SLOTS];
  logic [NUM_SLOTS*CARD_W-1:0]   reset_flat;
  logic [NUM_SLOTS*CARD_W-1:0]   commit_flat;
  logic [3:0]                    ph_d;
  logic [2:0]                    slot_d;
  logic [CARD_W-1:0]             card_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
`ifdef SLOTMAKER_DEFAULT_MAP_EN
      localparam logic [CARD_W-1:0] RST_CARD =
        (gi == 4) ? CARD_W'(CARD_MOCKINGBOARD) :
        (gi == 7) ? CARD_W'(CARD_SUPERSPRITE)  : CARD_W'(CARD_NONE);
`else
      localparam logic [CARD_W-1:0] RST_CARD = CARD_W'(CARD_NONE);
`endif
      assign reset_card[gi] = RST_CARD;
      assign reset_flat[gi*CARD_W +: CARD_W] = RST_CARD;
      // The last attach (slot 7) lands on the same edge as the commit, so fold it in here.
      assign commit_flat[gi*CARD_W +: CARD_W] =
        (seq_strobe_q && seq_slot_q == 3'(gi)) ? seq_card_q : snapshot_q[gi];
    end
  endgenerate

  // Forward a same-cycle CPU write so the broadcast card always equals the shadow value.
  always_comb begin
    ph_d   = ph_q + 4'd1;
    slot_d = ph_d[3:1];
    card_d = (cfg_wr && cfg_slot == slot_d) ? cfg_card_i : shadow_q[slot_d];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      ph_q           <= 4'd0;
      seq_slot_q     <= 3'd0;
      seq_card_q     <= '0;
      seq_clear_q    <= 1'b0;
      seq_strobe_q   <= 1'b0;
      seq_busy_q     <= 1'b0;
      commit_pulse_q <= 1'b0;
      active_map_q   <= reset_flat;
    end else begin
      seq_slot_q     <= 3'd0;
      seq_card_q     <= '0;
      seq_clear_q    <= 1'b0;
      seq_strobe_q   <= 1'b0;
      commit_pulse_q <= 1'b0;
      if (cfg_reconfig) begin
        state_q     <= SWEEP;
        ph_q        <= 4'd0;
        seq_clear_q <= 1'b1;
        seq_busy_q  <= 1'b1;
      end else begin
        case (state_q)
          SWEEP: begin
            seq_busy_q <= 1'b1;
            if (ph_q == 4'd15) begin
              state_q        <= COMMIT;
              ph_q           <= 4'd0;
              active_map_q   <= commit_flat;
              commit_pulse_q <= 1'b1;
            end else begin
              ph_q         <= ph_d;
              seq_slot_q   <= slot_d;
              seq_clear_q  <= ~ph_d[0];
              seq_strobe_q <= ph_d[0];
              if (ph_d[0]) seq_card_q <= card_d;
            end
          end
          COMMIT: begin
            state_q    <= IDLE;
            seq_busy_q <= 1'b0;
          end
          default: begin
            state_q    <= IDLE;
            seq_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_card_o_q <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k]   <= reset_card[k];
        snapshot_q[k] <= reset_card[k];
      end
    end else begin
      if (cfg_wr) shadow_q[cfg_slot] <= cfg_card_i;
      cfg_card_o_q <= shadow_q[cfg_slot];
      if (seq_strobe_q) snapshot_q[seq_slot_q] <= seq_card_q;
    end
  end

  assign cfg_card_o   = cfg_card_o_q;
  assign seq_busy     = seq_busy_q;
  assign seq_slot     = seq_slot_q;
  assign seq_card     = seq_card_q;
  assign seq_clear    = seq_clear_q;
  assign seq_strobe   = seq_strobe_q;
  assign active_map   = active_map_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_slotmaker_sequencer.sv
// Self-checking bench for slotmaker_sequencer: attach strobes and committed maps are
// predicted from a shadow model and scoreboarded; sweep timing is checked cycle by cycle.
module tb_slotmaker_sequencer;

  logic        clk;
  logic        resetn;
  logic [2:0]  cfg_slot;
  logic [7:0]  cfg_card_i;
  logic        cfg_wr;
  logic        cfg_reconfig;
  logic [7:0]  cfg_card_o;
  logic        seq_busy;
  logic [2:0]  seq_slot;
  logic [7:0]  seq_card;
  logic        seq_clear;
  logic        seq_strobe;
  logic [63:0] active_map;
  logic        commit_pulse;

  typedef struct packed {
    logic [2:0] slot;
    logic [7:0] card;
  } strobe_t;

  strobe_t     strobe_q[$];
  logic [63:0] map_q[$];
  logic [7:0]  shadow_m [8];
  logic [63:0] reset_map;
  int          n_cmp;
  int          n_bad;

  slotmaker_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_slot     (cfg_slot),
    .cfg_card_i   (cfg_card_i),
    .cfg_wr       (cfg_wr),
    .cfg_reconfig (cfg_reconfig),
    .cfg_card_o   (cfg_card_o),
    .seq_busy     (seq_busy),
    .seq_slot     (seq_slot),
    .seq_card     (seq_card),
    .seq_clear    (seq_clear),
    .seq_strobe   (seq_strobe),
    .active_map   (active_map),
    .commit_pulse (commit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = shadow_m[i];
    return m;
  endfunction

  task automatic push_sweep();
    strobe_t e;
    strobe_q.delete();
    map_q.delete();
    for (int i = 0; i < 8; i++) begin
      e.slot = i[2:0];
      e.card = shadow_m[i];
      strobe_q.push_back(e);
    end
    map_q.push_back(pack_model());
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) shadow_m[i] = reset_map[i*8 +: 8];
    strobe_q.delete();
    map_q.delete();
  endtask

  task automatic write_slot(input logic [2:0] s, input logic [7:0] c);
    cfg_slot   = s;
    cfg_card_i = c;
    cfg_wr     = 1'b1;
    shadow_m[s] = c;
    tick();
    cfg_wr = 1'b0;
  endtask

  // Called right after the reconfig cycle T was driven; checks cycles T+1..T+total.
  task automatic sweep_check(input int restart_k, input int wr_k, input logic [7:0] wr_card,
                             input int total);
    int         base;
    int         p;
    logic [3:0] pb;
    logic [7:0] expv;
    for (int k = 1; k <= total; k++) begin
      tick();
      cfg_wr       = 1'b0;
      cfg_reconfig = 1'b0;
      base = (restart_k > 0 && k > restart_k) ? restart_k : 0;
      p    = k - 1 - base;
      pb   = p[3:0];
      if (p <= 15)      expv = {1'b1, ~pb[0], pb[0], 1'b0, pb[3:1]};
      else if (p == 16) expv = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
      else              expv = 8'h00;
      chk_val($sformatf("cyc T+%0d busy/clr/stb/commit/slot", k),
              {56'd0, seq_busy, seq_clear, seq_strobe, commit_pulse, seq_slot}, {56'd0, expv});
      if (k == restart_k) begin
        cfg_reconfig = 1'b1;
        push_sweep();
      end
      if (k == wr_k) begin
        cfg_slot    = 3'd0;
        cfg_card_i  = wr_card;
        cfg_wr      = 1'b1;
        shadow_m[0] = wr_card;
      end
    end
  endtask

  // Scoreboard side: every attach strobe and commit pulse consumes one prediction.
  always @(negedge clk) begin
    if (resetn) begin
      if (seq_strobe) begin
        if (seq_clear) chk_val("clear_and_strobe", 64'd1, 64'd0);
        if (strobe_q.size() == 0) chk_val("sb_strobe_unexpected", 64'd1, 64'd0);
        else begin
          strobe_t e;
          e = strobe_q.pop_front();
          chk_val($sformatf("sb_strobe slot%0d", e.slot), {53'd0, seq_slot, seq_card},
                  {53'd0, e.slot, e.card});
        end
      end
      if (commit_pulse) begin
        if (map_q.size() == 0) chk_val("sb_commit_unexpected", 64'd1, 64'd0);
        else chk_val("sb_commit_map", active_map, map_q.pop_front());
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef SLOTMAKER_DEFAULT_MAP_EN
    reset_map = 64'h0200_0001_0000_0000;
`else
    reset_map = 64'd0;
`endif
    model_reset();
    resetn       = 1'b0;
    cfg_slot     = 3'd0;
    cfg_card_i   = 8'd0;
    cfg_wr       = 1'b0;
    cfg_reconfig = 1'b0;
    repeat (3) tick();

    chk_val("reset_ctrl", {59'd0, seq_busy, seq_clear, seq_strobe, commit_pulse, 1'b0}, 64'd0);
    chk_val("reset_seq_slot_card", {53'd0, seq_slot, seq_card}, 64'd0);
    chk_val("reset_cfg_card_o", {56'd0, cfg_card_o}, 64'd0);
    chk_val("reset_active_map", active_map, reset_map);
    resetn = 1'b1;
    tick();

    // Write then read back slot 3: old value one cycle later, new value two cycles later.
    write_slot(3'd3, 8'h05);
    chk_val("rd_lat1_slot3", {56'd0, cfg_card_o}, {56'd0, reset_map[31:24]});
    tick();
    chk_val("rd_lat2_slot3", {56'd0, cfg_card_o}, 64'h05);
    chk_val("map_after_write", active_map, reset_map);

    write_slot(3'd3, 8'h11);
    write_slot(3'd1, 8'hA1);
    write_slot(3'd6, 8'h66);
    write_slot(3'd0, 8'h77);

    // Same-cycle write and reconfig: the sweep must carry the new slot 3 card.
    cfg_slot     = 3'd3;
    cfg_card_i   = 8'h05;
    cfg_wr       = 1'b1;
    cfg_reconfig = 1'b1;
    shadow_m[3]  = 8'h05;
    push_sweep();
    sweep_check(0, 0, 8'h00, 18);
    chk_val("map_slot3_after_commit", {56'd0, active_map[31:24]}, 64'h05);

    // Restart at T+10: no commit at T+17, commit at T+27, busy never drops.
    cfg_reconfig = 1'b1;
    push_sweep();
    sweep_check(10, 0, 8'h00, 28);

    // Write slot 0 at T+4 after it was attached: commit keeps the old card.
    cfg_slot     = 3'd0;
    cfg_reconfig = 1'b1;
    push_sweep();
    sweep_check(0, 4, 8'h09, 18);
    chk_val("map_slot0_kept", {56'd0, active_map[7:0]}, 64'h77);
    chk_val("rd_slot0_new", {56'd0, cfg_card_o}, 64'h09);

    // Asynchronous reset in the middle of cycle T+5 of a sweep.
    cfg_reconfig = 1'b1;
    push_sweep();
    tick();
    cfg_reconfig = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    chk_val("async_rst_ctrl", {59'd0, seq_busy, seq_clear, seq_strobe, commit_pulse, 1'b0}, 64'd0);
    chk_val("async_rst_seq", {53'd0, seq_slot, seq_card}, 64'd0);
    chk_val("async_rst_cfg_card_o", {56'd0, cfg_card_o}, 64'd0);
    chk_val("async_rst_map", active_map, reset_map);
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;
    repeat (20) tick();
    chk_val("post_rst_idle", {56'd0, 7'd0, seq_busy}, 64'd0);
    chk_val("post_rst_map", active_map, reset_map);
    chk_val("post_rst_slot0", {56'd0, cfg_card_o}, {56'd0, reset_map[7:0]});

    chk_val("sb_strobe_drained", 64'(strobe_q.size()), 64'd0);
    chk_val("sb_commit_drained", 64'(map_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
